// File: rtl/e_mdu_pkg.sv
// Shared constants for the E-stage multiply/divide unit: operation codes,
// FSM state encodings and a small decode helper.
package e_mdu_pkg;

    // MDU operation codes driven by the controller on op
    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;

    // FSM states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CALC = 1'b1;

    // True for the operations that occupy the unit for multiple cycles
    function automatic logic is_calc_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    // True for the multiply flavours (selects the shorter latency)
    function automatic logic is_mult_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit. Owns HI/LO, latches operands on a start
// strobe, and commits the result after a fixed latency while reporting busy.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] RD
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [0:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;

    // Result datapath, evaluated from the latched operands
    logic [63:0] prod_s_d;
    logic [63:0] prod_u_d;
    logic        a_neg_d;
    logic        b_neg_d;
    logic [31:0] dvd_d;
    logic [31:0] dvs_d;
    logic [31:0] dvs_safe_d;
    logic [31:0] quo_d;
    logic [31:0] rem_d;
    logic [31:0] res_hi_d;
    logic [31:0] res_lo_d;
    logic        res_wr_d;

    // Combinational product and sign-magnitude division of the staged operands
    always_comb begin
        prod_s_d   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u_d   = {32'd0, a_q} * {32'd0, b_q};

        // Signed divide works on magnitudes; 0x80000000 keeps its magnitude
        // as an unsigned value, so the overflow case falls out naturally.
        a_neg_d    = (op_q == MDU_DIV) && a_q[31];
        b_neg_d    = (op_q == MDU_DIV) && b_q[31];
        dvd_d      = a_neg_d ? (32'd0 - a_q) : a_q;
        dvs_d      = b_neg_d ? (32'd0 - b_q) : b_q;
        // Keep the divider well defined on B==0; its result is discarded then
        dvs_safe_d = (dvs_d == 32'd0) ? 32'd1 : dvs_d;
        quo_d      = dvd_d / dvs_safe_d;
        rem_d      = dvd_d % dvs_safe_d;

        res_hi_d   = 32'd0;
        res_lo_d   = 32'd0;
        res_wr_d   = 1'b0;
        case (op_q)
            MDU_MULT: begin
                {res_hi_d, res_lo_d} = prod_s_d;
                res_wr_d = 1'b1;
            end
            MDU_MULTU: begin
                {res_hi_d, res_lo_d} = prod_u_d;
                res_wr_d = 1'b1;
            end
            MDU_DIV, MDU_DIVU: begin
                // Quotient truncates toward zero, remainder follows dividend
                res_lo_d = (a_neg_d ^ b_neg_d) ? (32'd0 - quo_d) : quo_d;
                res_hi_d = a_neg_d ? (32'd0 - rem_d) : rem_d;
                res_wr_d = (b_q != 32'd0);
            end
            default: begin
                res_wr_d = 1'b0;
            end
        endcase
    end

    // Command acceptance, latency countdown and HI/LO commit
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MDU_NONE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (is_calc_op(op)) begin
                            op_q    <= op;
                            a_q     <= A;
                            b_q     <= B;
                            cnt_q   <= is_mult_op(op) ? CNT_W'(MULT_CYCLES)
                                                      : CNT_W'(DIV_CYCLES);
                            state_q <= ST_CALC;
                        end else if (op == MDU_MTHI) begin
                            hi_q <= A;
                        end else if (op == MDU_MTLO) begin
                            lo_q <= A;
                        end
                    end
                end
                default: begin
                    // Starts arriving here are ignored; the stall unit
                    // should never let them happen.
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_IDLE;
                        if (res_wr_d) begin
                            hi_q <= res_hi_d;
                            lo_q <= res_lo_d;
                        end
                    end
                end
            endcase
        end
    end

    // Read-back mux for mfhi/mflo, combinational from the current registers
    always_comb begin
        case (op)
            MDU_MFHI: RD = hi_q;
            MDU_MFLO: RD = lo_q;
            default:  RD = 32'd0;
        endcase
    end

    assign busy = (state_q == ST_CALC);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: a vector table of arithmetic cases run
// through a result scoreboard, plus hand-written multi-cycle corner cases.
module tb_e_mdu;
    import e_mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] RD;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    vec_t vecs [10];
    exp_t sb_q [$];

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO),
        .RD    (RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end else begin
            $display("ok   %s: %08h", name, act);
        end
    endtask

    // Advance one clock, then settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge with the given command
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        step();
        start = 1'b0;
        op    = MDU_NONE;
    endtask

    // Count busy samples from now, checking HI/LO hold their old values
    task automatic wait_done(input string name, input logic [31:0] hold_hi,
                             input logic [31:0] hold_lo, output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            if (n == 2) begin
                check({name, " hold HI"}, HI, hold_hi);
                check({name, " hold LO"}, LO, hold_lo);
            end
            step();
        end
    endtask

    // Pop the oldest expectation and compare it against the finished DUT
    task automatic sb_check(input int n_busy);
        exp_t e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb_q.pop_front();
            check({e.name, " busy cycles"}, 32'(n_busy), 32'(e.cyc));
            check({e.name, " HI"}, HI, e.hi);
            check({e.name, " LO"}, LO, e.lo);
        end
    endtask

    // Issue one multi-cycle op, scoreboard it, and wait for completion
    task automatic run_op(input string name, input logic [3:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int cyc);
        logic [31:0] hh;
        logic [31:0] ll;
        int n;
        hh = HI;
        ll = LO;
        sb_q.push_back('{name, ehi, elo, cyc});
        issue(o, a, b);
        wait_done(name, hh, ll, n);
        sb_check(n);
    endtask

    initial begin
        int n;

        vecs[0] = '{"mult -1*2",      MDU_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[1] = '{"multu ffff*2",   MDU_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2] = '{"div -7/2",       MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{"divu 7/2",       MDU_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
        vecs[4] = '{"div min/-1",     MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[5] = '{"div 7/-2",       MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[6] = '{"mult max*max",   MDU_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};
        vecs[7] = '{"multu ffff^2",   MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[8] = '{"divu ffff/10",   MDU_DIVU,  32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999, 10};
        vecs[9] = '{"div -100/7",     MDU_DIV,   32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFF2, 10};

        reset = 1'b1;
        start = 1'b0;
        op    = MDU_NONE;
        A     = 32'd0;
        B     = 32'd0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset HI", HI, 32'd0);
        check("reset LO", LO, 32'd0);
        op = MDU_MFHI;
        #1;
        check("reset RD mfhi", RD, 32'd0);
        op = MDU_NONE;

        // Arithmetic table
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].cyc);
        end

        // MTHI / MTLO take effect on the start edge without busy
        issue(MDU_MTHI, 32'h00001234, 32'd0);
        check("mthi HI", HI, 32'h00001234);
        check("mthi busy", {31'd0, busy}, 32'd0);
        issue(MDU_MTLO, 32'h00005678, 32'd0);
        check("mtlo LO", LO, 32'h00005678);
        check("mtlo busy", {31'd0, busy}, 32'd0);

        // Divide by zero keeps HI/LO after full latency
        run_op("div by 0", MDU_DIV, 32'h00000064, 32'd0, 32'h00001234, 32'h00005678, 10);
        run_op("divu by 0", MDU_DIVU, 32'h00000064, 32'd0, 32'h00001234, 32'h00005678, 10);
        op = MDU_MFHI;
        #1;
        check("RD mfhi", RD, 32'h00001234);
        op = MDU_MFLO;
        #1;
        check("RD mflo", RD, 32'h00005678);
        op = MDU_MTHI;
        #1;
        check("RD other op", RD, 32'd0);
        op = MDU_NONE;

        // Starts while busy are ignored
        sb_q.push_back('{"mult with ignored starts", 32'd0, 32'd42, 5});
        issue(MDU_MULT, 32'd6, 32'd7);
        start = 1'b1; op = MDU_DIVU; A = 32'd9; B = 32'd3;
        step();
        start = 1'b1; op = MDU_MTLO; A = 32'h0000DEAD; B = 32'd0;
        step();
        start = 1'b0; op = MDU_NONE;
        wait_done("mult with ignored starts", 32'h00001234, 32'h00005678, n);
        sb_check(n + 2);
        step();
        check("no late start busy", {31'd0, busy}, 32'd0);
        check("no late start LO", LO, 32'd42);

        // Reset aborts an in-flight divide
        issue(MDU_DIV, 32'd100, 32'd7);
        step();
        step();
        step();
        check("abort busy before reset", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb_q.delete();
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort HI", HI, 32'd0);
        check("abort LO", LO, 32'd0);
        step();
        check("abort stays idle", {31'd0, busy}, 32'd0);
        run_op("multu 3*4", MDU_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 5);

        // Back-to-back: the second start lands right as busy falls
        run_op("mult 3*5", MDU_MULT, 32'd3, 32'd5, 32'd0, 32'd15, 5);
        run_op("divu 20/6", MDU_DIVU, 32'd20, 32'd6, 32'd2, 32'd3, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
